// File: rtl/axi4_rd_master_if.sv
// Core-side request/response and AXI4 AR/R channel bundle for axi4_rd_master.
// master = the read initiator's view, slave = the core/interconnect side.
interface axi4_rd_master_if #(
    parameter int unsigned LINE_BEATS = 4
);
    logic                         req_valid;
    logic                         req_ready;
    logic [31:0]                  req_addr;
    logic                         req_line;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [32*LINE_BEATS-1:0]     rsp_data;
    logic                         rsp_err;

    logic [31:0]                  araddr;
    logic                         arvalid;
    logic                         arready;
    logic [3:0]                   arid;
    logic [7:0]                   arlen;
    logic [2:0]                   arsize;
    logic [1:0]                   arburst;

    logic [31:0]                  rdata;
    logic [1:0]                   rresp;
    logic                         rvalid;
    logic                         rready;
    logic                         rlast;
    logic [3:0]                   rid;

    modport master (
        input  req_valid, req_addr, req_line, rsp_ready,
        input  arready, rdata, rresp, rvalid, rlast, rid,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output araddr, arvalid, arid, arlen, arsize, arburst, rready
    );

    modport slave (
        output req_valid, req_addr, req_line, rsp_ready,
        output arready, rdata, rresp, rvalid, rlast, rid,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  araddr, arvalid, arid, arlen, arsize, arburst, rready
    );
endinterface

// File: rtl/axi4_rd_master.sv
// Single-outstanding AXI4 read initiator: one request -> one AR burst -> assembled line.
// Optional read watchdog enabled by defining AXI_RD_TIMEOUT_EN.
module axi4_rd_master #(
    parameter int unsigned LINE_BEATS     = 4,
    parameter int unsigned AXI_ID         = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clock,
    input  logic             reset,
    axi4_rd_master_if.master bus
);
    localparam int unsigned IDX_W    = $clog2(LINE_BEATS);
    localparam int unsigned CNT_W    = IDX_W + 1;
    localparam logic [7:0]  LINE_LEN = 8'(LINE_BEATS - 1);
    localparam logic [3:0]  ID       = 4'(AXI_ID);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    if (LINE_BEATS < 2 || LINE_BEATS > 16 || (LINE_BEATS & (LINE_BEATS - 1)) != 0 ||
        TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("axi4_rd_master: unsupported LINE_BEATS or TIMEOUT_CYCLES");
    end

    logic [1:0]                   state_q,     state_d;
    logic [31:0]                  araddr_q,    araddr_d;
    logic [7:0]                   arlen_q,     arlen_d;
    logic [CNT_W-1:0]             beat_q,      beat_d;
    logic [LINE_BEATS-1:0][31:0]  line_q,      line_d;
    logic                         err_q,       err_d;
    logic                         req_ready_q, req_ready_d;
    logic                         arvalid_q,   arvalid_d;
    logic                         rready_q,    rready_d;
    logic                         rsp_valid_q, rsp_valid_d;

    logic ar_hs;
    logic r_hs;
    logic at_last;
    logic beat_err;
    logic can_accept;

`ifdef AXI_RD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             dead_q, dead_d;
    logic             tmo_hit;

    // A timed-out burst may still deliver beats, so the block stays locked until reset.
    assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign can_accept = ~dead_q;
`else
    assign can_accept = 1'b1;
`endif

    assign ar_hs    = arvalid_q & bus.arready;
    assign r_hs     = rready_q & bus.rvalid;
    assign at_last  = (8'(beat_q) == arlen_q);
    // Bad response, foreign ID, or rlast disagreeing with the expected final beat.
    assign beat_err = (bus.rresp >= 2'b10) | (bus.rid != ID) | (bus.rlast != at_last);

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        beat_d   = beat_q;
        line_d   = line_q;
        err_d    = err_q;
`ifdef AXI_RD_TIMEOUT_EN
        tmo_d    = tmo_q;
        dead_d   = dead_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && can_accept) begin
                    araddr_d = bus.req_addr & 32'hFFFF_FFFC;
                    arlen_d  = bus.req_line ? LINE_LEN : 8'd0;
                    beat_d   = '0;
                    line_d   = '0;
                    err_d    = 1'b0;
                    state_d  = S_ADDR;
`ifdef AXI_RD_TIMEOUT_EN
                    tmo_d    = '0;
`endif
                end
            end
            S_ADDR: begin
                if (ar_hs) begin
                    state_d = S_DATA;
                end
`ifdef AXI_RD_TIMEOUT_EN
                if (ar_hs) begin
                    tmo_d = '0;
                end else if (tmo_hit) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    dead_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_DATA: begin
                if (r_hs) begin
                    line_d[beat_q[IDX_W-1:0]] = bus.rdata;
                    beat_d = beat_q + 1'b1;
                    if (beat_err) begin
                        err_d = 1'b1;
                    end
                    if (bus.rlast || at_last) begin
                        state_d = S_RESP;
                    end
                end
`ifdef AXI_RD_TIMEOUT_EN
                if (r_hs) begin
                    tmo_d = '0;
                end else if (tmo_hit) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    dead_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef AXI_RD_TIMEOUT_EN
        req_ready_d = (state_d == S_IDLE) && !dead_d;
`else
        req_ready_d = (state_d == S_IDLE);
`endif
        arvalid_d   = (state_d == S_ADDR);
        rready_d    = (state_d == S_DATA);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            araddr_q    <= '0;
            arlen_q     <= '0;
            beat_q      <= '0;
            line_q      <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            beat_q      <= beat_d;
            line_q      <= line_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef AXI_RD_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_q  <= '0;
            dead_q <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            dead_q <= dead_d;
        end
    end
`endif

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = line_q;
    assign bus.rsp_err   = err_q;
    assign bus.araddr    = araddr_q;
    assign bus.arvalid   = arvalid_q;
    assign bus.arid      = ID;
    assign bus.arlen     = arlen_q;
    assign bus.arsize    = 3'b010;
    assign bus.arburst   = 2'b01;
    assign bus.rready    = rready_q;
endmodule

// File: tb/tb_axi4_rd_master.sv
// Randomized + directed bench for axi4_rd_master against a transaction-level reference model.
module tb_axi4_rd_master;
    localparam int unsigned LB  = 4;
    localparam int unsigned TMO = 16;
    localparam int unsigned NB  = LB + 2;
    localparam logic [3:0]  ID  = 4'd0;

    logic clock = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] b_data [NB];
    logic [1:0]  b_resp [NB];
    logic [3:0]  b_id   [NB];
    logic        b_last [NB];

    axi4_rd_master_if #(.LINE_BEATS(LB)) bus ();

    axi4_rd_master #(
        .LINE_BEATS    (LB),
        .AXI_ID        (0),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: the burst ends at the first rlast or at beat arlen; every accepted beat lands in its slot.
    function automatic void model(input logic line, output int cnt,
                                  output logic [127:0] data, output logic err);
        int last_idx;
        last_idx = line ? int'(LB) - 1 : 0;
        cnt  = 0;
        data = '0;
        err  = 1'b0;
        for (int i = 0; i < int'(NB); i++) begin
            data[32*i +: 32] = b_data[i];
            if (b_resp[i][1] || b_id[i] != ID || b_last[i] != (i == last_idx)) err = 1'b1;
            cnt++;
            if (b_last[i] || i == last_idx) break;
        end
    endfunction

    task automatic load_beats(input logic [31:0] d0, input int last_at);
        for (int i = 0; i < int'(NB); i++) begin
            b_data[i] = d0 + 32'(i);
            b_resp[i] = 2'b00;
            b_id[i]   = ID;
            b_last[i] = (i == last_at);
        end
    endtask

    task automatic drive_beat(input int i);
        bus.rdata  = b_data[i];
        bus.rresp  = b_resp[i];
        bus.rid    = b_id[i];
        bus.rlast  = b_last[i];
        bus.rvalid = 1'b1;
    endtask

    // One full transaction; entered and left at a falling edge.
    task automatic run_txn(input logic [31:0] addr, input logic line, input int ar_dly,
                           input int gap_min, input int gap_max, input bit chk_lat);
        int           lat, acc, exp_cnt, k, g, h;
        logic [127:0] exp_data;
        logic         exp_err;
        logic [49:0]  exp_ar;
        model(line, exp_cnt, exp_data, exp_err);
        exp_ar = {1'b1, addr & 32'hFFFF_FFFC, (line ? 8'(LB - 1) : 8'd0), 3'd2, 2'd1, ID};

        check_eq("req_ready_idle", 128'(bus.req_ready), 128'(1'b1));
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_line  = line;
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_line  = 1'($urandom_range(1, 0));
        lat = 1;
        check_eq("ar_fields", 128'({bus.arvalid, bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.arid}),
                 128'(exp_ar));
        for (int j = 0; j < ar_dly; j++) begin
            bus.arready = 1'b0;
            @(negedge clock);
            lat++;
            check_eq("ar_hold", 128'({bus.arvalid, bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.arid}),
                     128'(exp_ar));
        end
        bus.arready = 1'b1;
        @(negedge clock);
        lat++;
        bus.arready = 1'b0;
        check_eq("data_entry", 128'({bus.arvalid, bus.rready, bus.req_ready}), 128'(3'b010));

        acc = 0;
        for (int i = 0; i < int'(NB); i++) begin
            g = int'($urandom_range(gap_max, gap_min));
            for (int j = 0; j < g; j++) begin
                bus.rvalid = 1'b0;
                @(negedge clock);
                lat++;
            end
            if (!bus.rready) break;
            drive_beat(i);
            @(negedge clock);
            lat++;
            acc++;
        end
        bus.rvalid = 1'b0;

        k = 0;
        while (!bus.rsp_valid && k < 50) begin
            @(negedge clock);
            k++;
        end
        check_eq("rsp_valid", 128'(bus.rsp_valid), 128'(1'b1));
        if (chk_lat) check_eq("latency", 128'(lat), 128'(3));
        check_eq("beats_taken", 128'(acc), 128'(exp_cnt));
        check_eq("rsp_data", bus.rsp_data, exp_data);
        check_eq("rsp_err", 128'(bus.rsp_err), 128'(exp_err));

        h = int'($urandom_range(2, 0));
        for (int j = 0; j < h; j++) @(negedge clock);
        check_eq("rsp_hold", {bus.rsp_valid, bus.rsp_err, bus.rsp_data[125:0]},
                 {1'b1, exp_err, exp_data[125:0]});
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        check_eq("rsp_done", 128'({bus.rsp_valid, bus.req_ready}), 128'(2'b01));
    endtask

    initial begin
        int   k;
        int   last_idx;
        logic line;

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_line  = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.arready   = 1'b0;
        bus.rdata     = '0;
        bus.rresp     = '0;
        bus.rvalid    = 1'b0;
        bus.rlast     = 1'b0;
        bus.rid       = '0;
        repeat (2) @(negedge clock);
        check_eq("reset_ctl", 128'({bus.req_ready, bus.arvalid, bus.rready, bus.rsp_valid, bus.rsp_err}),
                 128'(5'b10000));
        check_eq("reset_ar", 128'({bus.araddr, bus.arlen}), 128'(0));
        check_eq("reset_data", bus.rsp_data, 128'(0));
        reset = 1'b0;
        @(negedge clock);

        // Single word read with immediate AR/R.
        load_beats(32'h1234_5678, 0);
        run_txn(32'h0200_0000, 1'b0, 0, 0, 0, 1'b1);

        // Line read, 5-cycle AR backpressure, 2-cycle gaps between beats.
        load_beats(32'h0000_00A0, 3);
        run_txn(32'h8000_0013, 1'b1, 5, 2, 2, 1'b0);

        // SLVERR on beat 2.
        load_beats(32'h0000_0B00, 3);
        b_resp[2] = 2'b10;
        run_txn(32'h0000_4000, 1'b1, 1, 0, 1, 1'b0);

        // Early rlast on beat 1.
        load_beats(32'h0000_0C00, 1);
        run_txn(32'h0000_5004, 1'b1, 0, 0, 1, 1'b0);

        // Wrong RID.
        load_beats(32'hDEAD_BEEF, 0);
        b_id[0] = 4'd5;
        run_txn(32'h0000_6008, 1'b0, 0, 0, 0, 1'b0);

        // Reset while in DATA after two beats.
        load_beats(32'h0000_00C0, 3);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_1000;
        bus.req_line  = 1'b1;
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.arready   = 1'b1;
        @(negedge clock);
        bus.arready = 1'b0;
        drive_beat(0);
        @(negedge clock);
        drive_beat(1);
        @(negedge clock);
        bus.rvalid = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("rst_mid_ctl", 128'({bus.arvalid, bus.rready, bus.rsp_valid, bus.req_ready}), 128'(4'b0001));
        check_eq("rst_mid_data", bus.rsp_data, 128'(0));
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        load_beats(32'h0BAD_F00D, 0);
        run_txn(32'h0000_2000, 1'b0, 0, 0, 0, 1'b0);

        // Randomized traffic with occasional faults.
        for (int t = 0; t < 40; t++) begin
            line     = 1'($urandom_range(1, 0));
            last_idx = line ? int'(LB) - 1 : 0;
            for (int i = 0; i < int'(NB); i++) begin
                b_data[i] = $urandom;
                b_resp[i] = ($urandom_range(7, 0) == 0) ? 2'($urandom_range(3, 2)) : 2'($urandom_range(1, 0));
                b_id[i]   = ($urandom_range(9, 0) == 0) ? 4'($urandom_range(15, 1)) : ID;
                b_last[i] = (i == last_idx) ^ ($urandom_range(7, 0) == 0);
            end
            run_txn($urandom, line, int'($urandom_range(3, 0)), 0, 2, 1'b0);
        end

        // R channel goes silent after the AR handshake.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0040;
        bus.req_line  = 1'b0;
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.arready   = 1'b1;
        @(negedge clock);
        bus.arready = 1'b0;
        k = 0;
`ifdef AXI_RD_TIMEOUT_EN
        while (bus.rready && !bus.rsp_valid && k < 100) begin
            @(negedge clock);
            k++;
        end
        check_eq("tmo_cycles", 128'(k), 128'(TMO));
        check_eq("tmo_rsp", 128'({bus.rsp_valid, bus.rsp_err, bus.arvalid, bus.rready}), 128'(4'b1100));
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("tmo_locked", 128'({bus.req_ready, bus.rready, bus.rsp_valid}), 128'(3'b000));
`else
        while (bus.rready && !bus.rsp_valid && k < 1000) begin
            @(negedge clock);
            k++;
        end
        check_eq("no_tmo_wait", 128'(k), 128'(1000));
        check_eq("no_tmo_state", 128'({bus.rsp_valid, bus.rready}), 128'(2'b01));
`endif
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("post_reset", 128'({bus.req_ready, bus.rsp_valid}), 128'(2'b10));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/axi4_rd_master.md
Name: axi4_rd_master

Overview:
- Single-outstanding AXI4 read initiator. Converts a simple core-side request (single word or cache line) into one AR burst, collects the R beats into a line buffer, and returns the assembled result.
- Sits between the IFU/LSU request logic and the AXI interconnect. It is the initiator counterpart to the memory-mapped read responders (timer, SRAM, UART).

Parameters:
- LINE_BEATS, 4, beats per line request; power of two, 2..16; line read uses arlen = LINE_BEATS-1.
- AXI_ID, 0, 4-bit ID driven on arid and expected on rid.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_addr  in  32  byte address; bits [1:0] ignored, forced 0 on araddr
- req_line  in  1  1 = LINE_BEATS-beat INCR burst; 0 = single beat
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_data  out  32*LINE_BEATS  beat i at [32i+31:32i]; unfilled beats 0
- rsp_err  out  1  any error during the transaction
- araddr out 32; arvalid out 1; arready in 1; arid out 4; arlen out 8; arsize out 3; arburst out 2
- rdata in 32; rresp in 2; rvalid in 1; rready out 1; rlast in 1; rid in 4

Behaviour:
- States: IDLE, ADDR, DATA, RESP. Encoded register, async reset to IDLE.
- Reset values: req_ready=1, arvalid=0, rready=0, rsp_valid=0, rsp_err=0, rsp_data=0, araddr=0, arlen=0.
- Reset mid-operation aborts immediately. No beats are retained and no response is produced.
- IDLE:
  - req_ready=1.
  - On req_valid: latch the address as {req_addr[31:2],2'b00}.
  - Latch arlen = req_line ? LINE_BEATS-1 : 0.
  - Clear the line buffer, beat counter and error flag.
  - Go to ADDR next cycle.
  - req_ready=0 in every other state.
- ADDR:
  - arvalid=1 with the latched araddr/arlen, arid=AXI_ID, arsize=3'b010, arburst=2'b01 (INCR).
  - arvalid stays high and all AR fields stay stable until arready.
  - On arvalid & arready: go to DATA. A one-cycle AR handshake is legal.
- DATA:
  - rready=1.
  - Each rvalid beat writes rdata into slot beat_cnt and increments beat_cnt.
  - beat_cnt width is clog2(LINE_BEATS)+1 bits and never wraps within a transaction.
- Error flag (sticky until the next request) is set by any of:
  - rresp[1]=1 (SLVERR/DECERR);
  - rid != AXI_ID;
  - rlast=1 on a beat other than beat arlen;
  - rlast=0 on beat arlen.
- Exit DATA to RESP on the first of:
  - a beat with rlast=1;
  - the beat with beat_cnt==arlen, even if rlast=0.
- Extra beats after exit are not accepted, because rready=0 outside DATA.
- Beats with rid mismatch are still stored.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are stable.
  - On rsp_ready: return to IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake.
- Minimum latency from request accept to rsp_valid, single beat with arready and rvalid both immediate: 3 cycles (ADDR, DATA, RESP).
- All outputs are registered or decoded from state only. There is no combinational path from R/AR inputs to req_ready or rsp_valid.

Optional Feature:
- Macro: AXI_RD_TIMEOUT_EN.
- Defined:
  - A counter of clog2(TIMEOUT_CYCLES)+1 bits runs in ADDR and DATA.
  - It clears on every AR handshake and on every accepted R beat.
  - On reaching TIMEOUT_CYCLES: go to RESP with rsp_err=1, arvalid=0, rready=0.
  - Late beats from the timed-out burst are never accepted. Recovery requires reset.
- Not defined:
  - No counter exists; the block waits indefinitely in ADDR/DATA.
  - The TIMEOUT_CYCLES parameter is ignored.

Test Plan:
- Single read: req_addr=0x0200_0000, req_line=0.
  - Required AR: araddr=0x0200_0000, arlen=0, arsize=2, arburst=1.
  - Responder returns rdata=0x1234_5678, rlast=1, rresp=0 → rsp_data[31:0]=0x1234_5678, upper beats 0, rsp_err=0, rsp_valid 3 cycles after accept.
- Line read with backpressure: req_addr=0x8000_0013, req_line=1.
  - Required AR: araddr=0x8000_0010, arlen=3.
  - arready delayed 5 cycles; arvalid and all AR fields stay stable throughout.
  - Beats 0xA0..0xA3 arrive with 2-cycle rvalid gaps → rsp_data = {A3,A2,A1,A0}, rsp_err=0.
- Error response: line read where beat 2 has rresp=2'b10 → all 4 beats captured, rsp_err=1.
- Protocol faults:
  - rlast on beat 1 of a 4-beat line → exit after 2 beats, beats 2/3 read as 0, rsp_err=1.
  - rid=5 with AXI_ID=0 → rsp_err=1.
- Reset mid-DATA: assert reset after beat 1 of a line read → same cycle arvalid=0, rready=0, rsp_valid=0, req_ready=1. A following single read completes normally with rsp_err=0.
- With AXI_RD_TIMEOUT_EN and TIMEOUT_CYCLES=16: hold rvalid=0 after the AR handshake → rsp_valid=1 with rsp_err=1 after 16 cycles in DATA. Without the macro, the bench observes no response after 1000 cycles.
